// File: rtl/instr_prefetch_if.sv
// Fetch-side bus between the instruction prefetcher and the bus arbiter's instruction port.
interface instr_prefetch_if;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic [31:0] instr_read_value_in;
  logic        instr_ready_in;

  modport master (
    output instr_address_out,
    output instr_read_out,
    input  instr_read_value_in,
    input  instr_ready_in
  );

  modport slave (
    input  instr_address_out,
    input  instr_read_out,
    output instr_read_value_in,
    output instr_ready_in
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: fetches sequential words into a DEPTH-entry circular buffer.
// Optional INSTR_PREFETCH_STATS_EN adds stall_cycles_out, a count of request cycles without a grant.
module instr_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_in,
  input  logic [31:0]         redirect_pc_in,
  instr_prefetch_if.master    bus,
  output logic                instr_valid_out,
  output logic [31:0]         instr_out,
  output logic [31:0]         pc_out,
  input  logic                instr_accept_in
`ifdef INSTR_PREFETCH_STATS_EN
  ,
  output logic [31:0]         stall_cycles_out
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fetch_pc;

  logic read_req;
  logic push;
  logic pop;
  logic unused_pc_bits;

  // Request depends only on occupancy and redirect, never on the consumer's accept.
  assign read_req = (count < CNT_W'(DEPTH)) && !redirect_in;
  assign push     = read_req && bus.instr_ready_in;
  assign pop      = instr_valid_out && instr_accept_in && !redirect_in;

  assign bus.instr_read_out    = read_req;
  assign bus.instr_address_out = fetch_pc;

  assign instr_valid_out = (count != '0);
  assign instr_out       = instr_mem[rd_ptr];
  assign pc_out          = pc_mem[rd_ptr];

  assign unused_pc_bits = ^redirect_pc_in[1:0];

  // Pointer, occupancy and fetch address; reset beats redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_in) begin
      fetch_pc <= {redirect_pc_in[31:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.instr_read_value_in;
    end
  end

`ifdef INSTR_PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_out <= '0;
    end else if (read_req && !bus.instr_ready_in) begin
      stall_cycles_out <= stall_cycles_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed literal checks plus a queue-based reference model.
module tb_instr_prefetch;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_accept_in;
`ifdef INSTR_PREFETCH_STATS_EN
  logic [31:0] stall_cycles_out;
`endif

  instr_prefetch_if bus ();

  instr_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .bus             (bus.master),
    .instr_valid_out (instr_valid_out),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_accept_in (instr_accept_in)
`ifdef INSTR_PREFETCH_STATS_EN
    ,
    .stall_cycles_out(stall_cycles_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered {pc, word} pairs plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_stall;
  bit          known = 0;

  always @(negedge clk) begin : model
    bit   exp_rd;
    bit   do_push;
    bit   do_pop;
    ent_t e;
    exp_rd = (q.size() < DEPTH) && !redirect_in;
    if (known) begin
      chk("m_read", 32'(bus.instr_read_out), 32'(exp_rd));
      chk("m_addr", bus.instr_address_out, m_pc);
      chk("m_valid", 32'(instr_valid_out), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("m_pc_out", pc_out, q[0].pc);
        chk("m_instr", instr_out, q[0].w);
      end
`ifdef INSTR_PREFETCH_STATS_EN
      chk("m_stall", stall_cycles_out, m_stall);
`endif
    end
    if (reset) begin
      q.delete();
      m_pc    = RESET_PC;
      m_stall = 0;
      known   = 1;
    end else if (known) begin
      if (exp_rd && !bus.instr_ready_in) m_stall = m_stall + 1;
      if (redirect_in) begin
        q.delete();
        m_pc = {redirect_pc_in[31:2], 2'b00};
      end else begin
        do_push = exp_rd && bus.instr_ready_in;
        do_pop  = (q.size() != 0) && instr_accept_in;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.pc = m_pc;
          e.w  = bus.instr_read_value_in;
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                   = 1'b1;
    redirect_in             = 1'b0;
    redirect_pc_in          = 32'h0;
    bus.instr_ready_in      = 1'b1;
    bus.instr_read_value_in = 32'h0;
    instr_accept_in         = 1'b0;
    step();
    step();

    // Fill after reset: two fetches then the request drops.
    reset = 1'b0;
    bus.instr_read_value_in = 32'h1111_0000;
    #1;
    chk("rst_valid", 32'(instr_valid_out), 32'h0);
    chk("rst_addr", bus.instr_address_out, 32'h0);
    chk("rst_read", 32'(bus.instr_read_out), 32'h1);
    step();
    bus.instr_read_value_in = 32'h2222_0004;
    #1;
    chk("fill1_valid", 32'(instr_valid_out), 32'h1);
    chk("fill1_pc", pc_out, 32'h0);
    chk("fill1_instr", instr_out, 32'h1111_0000);
    chk("fill1_addr", bus.instr_address_out, 32'h4);
    step();
    #1;
    chk("full_read", 32'(bus.instr_read_out), 32'h0);
    chk("full_pc", pc_out, 32'h0);
    chk("full_instr", instr_out, 32'h1111_0000);
    chk("full_addr", bus.instr_address_out, 32'h8);

    // Full buffer with no accept holds everything.
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("hold_read", 32'(bus.instr_read_out), 32'h0);
      chk("hold_addr", bus.instr_address_out, 32'h8);
      chk("hold_pc", pc_out, 32'h0);
      chk("hold_instr", instr_out, 32'h1111_0000);
    end

    // Steady stream: one instruction per cycle.
    instr_accept_in = 1'b1;
    #1;
    chk("stream_pc0", pc_out, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.instr_read_value_in = 32'hD000_0000 + 32'(k);
      #1;
      chk("stream_valid", 32'(instr_valid_out), 32'h1);
      chk("stream_pc", pc_out, 32'(4 * k));
    end

    // Fill to two entries, then redirect with a concurrent accept.
    instr_accept_in = 1'b0;
    step();
    #1;
    chk("pre_redir_read", 32'(bus.instr_read_out), 32'h0);
    redirect_in     = 1'b1;
    redirect_pc_in  = 32'h0000_1003;
    instr_accept_in = 1'b1;
    #1;
    chk("redir_read", 32'(bus.instr_read_out), 32'h0);
    step();
    redirect_in     = 1'b0;
    instr_accept_in = 1'b0;
    bus.instr_read_value_in = 32'hBEEF_1000;
    #1;
    chk("redir_valid", 32'(instr_valid_out), 32'h0);
    chk("redir_addr", bus.instr_address_out, 32'h0000_1000);
    chk("redir_read2", 32'(bus.instr_read_out), 32'h1);
    step();
    #1;
    chk("redir_pc", pc_out, 32'h0000_1000);
    chk("redir_instr", instr_out, 32'hBEEF_1000);

    // Back-to-back redirects: last wins, no fetch meanwhile.
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h0000_2000;
    #1;
    chk("b2b_read1", 32'(bus.instr_read_out), 32'h0);
    step();
    redirect_pc_in = 32'h0000_3009;
    #1;
    chk("b2b_read2", 32'(bus.instr_read_out), 32'h0);
    step();
    redirect_in = 1'b0;
    #1;
    chk("b2b_addr", bus.instr_address_out, 32'h0000_3008);
    chk("b2b_valid", 32'(instr_valid_out), 32'h0);

    // Address wrap at the top of the address space.
    redirect_in    = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFE;
    step();
    redirect_in = 1'b0;
    bus.instr_read_value_in = 32'h7777_7777;
    #1;
    chk("wrap_addr0", bus.instr_address_out, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_instr", instr_out, 32'h7777_7777);
    chk("wrap_addr1", bus.instr_address_out, 32'h0);

    // Mid-stream reset discards entries; withheld grant holds the request.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.instr_ready_in = 1'b0;
    #1;
    chk("mrst_valid", 32'(instr_valid_out), 32'h0);
    chk("mrst_addr", bus.instr_address_out, RESET_PC);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("stall_read", 32'(bus.instr_read_out), 32'h1);
      chk("stall_addr", bus.instr_address_out, RESET_PC);
    end
`ifdef INSTR_PREFETCH_STATS_EN
    chk("stall_cnt", stall_cycles_out, 32'd3);
`endif
    reset = 1'b1;
    step();
`ifdef INSTR_PREFETCH_STATS_EN
    chk("stall_rst", stall_cycles_out, 32'd0);
`endif
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset                   = ($urandom_range(0, 99) == 0);
      redirect_in             = ($urandom_range(0, 19) == 0);
      redirect_pc_in          = $urandom();
      bus.instr_ready_in      = ($urandom_range(0, 9) < 7);
      instr_accept_in         = ($urandom_range(0, 9) < 6);
      bus.instr_read_value_in = $urandom();
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
- REQ-001: Parameter RESET_PC, default 32'h00000000, address of the first fetch after reset; bits [1:0] SHALL be zero.
- REQ-002: Parameter DEPTH, default 2, number of buffer entries; legal values are 2, 4 and 8.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: redirect_in  input  1  control-flow redirect request from the pipeline.
- REQ-006: redirect_pc_in  input  32  new fetch address, valid while redirect_in is high.
- REQ-007: instr_address_out  output  32  fetch address driven toward the bus arbiter instruction port.
- REQ-008: instr_read_out  output  1  fetch request toward the arbiter.
- REQ-009: instr_read_value_in  input  32  fetched word, valid in the same cycle as instr_ready_in.
- REQ-010: instr_ready_in  input  1  arbiter grant; a read completes combinationally in that same cycle.
- REQ-011: instr_valid_out  output  1  head buffer entry is valid.
- REQ-012: instr_out  output  32  head instruction word.
- REQ-013: pc_out  output  32  address of the head instruction.
- REQ-014: instr_accept_in  input  1  pipeline consumes the head entry when instr_valid_out is also high.

Function
- REQ-015: The block SHALL hold a circular buffer of DEPTH {pc, instr} entries with read pointer, write pointer and a count register of width clog2(DEPTH)+1.
- REQ-016: instr_read_out SHALL equal (count < DEPTH) && !redirect_in, and SHALL depend only on registered state and redirect_in (no path from instr_accept_in).
- REQ-017: instr_address_out SHALL equal the fetch_pc register at all times.
- REQ-018: Push: in a cycle with instr_read_out && instr_ready_in, {fetch_pc, instr_read_value_in} SHALL be written at the write pointer, and fetch_pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 32'h0).
- REQ-019: Pop: in a cycle with instr_valid_out && instr_accept_in && !redirect_in, the read pointer SHALL advance.
- REQ-020: A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
- REQ-021: instr_valid_out SHALL be (count != 0); instr_out and pc_out SHALL drive the head entry directly from storage with zero added latency.
- REQ-022: When the arbiter withholds instr_ready_in (a data access has priority), fetch_pc SHALL hold and the request SHALL stay asserted in the next cycle.
- REQ-023: Redirect: in a cycle with redirect_in high, the next state SHALL be count=0 and both pointers equal, with fetch_pc = {redirect_pc_in[31:2], 2'b00}; any concurrent accept SHALL be ignored and no push SHALL occur.
- REQ-024: Back-to-back redirects SHALL each take effect, the last one winning, with no fetch issued until redirect_in is low.
- REQ-025: Fetch-to-valid latency SHALL be one cycle: a word granted in cycle N SHALL appear as instr_valid_out in cycle N+1 if the buffer was empty.

Reset
- REQ-026: While reset is high, the next state SHALL be fetch_pc=RESET_PC, count=0 and pointers=0; reset SHALL take priority over redirect_in, push and pop.
- REQ-027: During the reset cycle, instr_read_out SHALL still follow REQ-016; after reset, instr_valid_out=0 and instr_address_out=RESET_PC; a reset asserted mid-stream SHALL discard all buffered entries.

Configuration
- REQ-028: Macro INSTR_PREFETCH_STATS_EN defined: the block SHALL add output stall_cycles_out (32 bits), which resets to 0 and increments, wrapping, every cycle with instr_read_out && !instr_ready_in.
- REQ-029: Macro INSTR_PREFETCH_STATS_EN undefined: the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-030: Reset, with instr_ready_in=1 and accept=0 -> reads at 0x0, 0x4, then instr_read_out=0 with count=2 (DEPTH=2); pc_out=0x0 and the head word equals the first value.
- REQ-031: Steady stream, with accept=1 and ready=1 every cycle -> one instruction per cycle and pc_out sequence 0x0, 0x4, 0x8...
- REQ-032: Buffer full, with accept held at 0 for 5 cycles -> instr_read_out=0, fetch_pc holds at 0x8, and the outputs are stable.
- REQ-033: redirect_in=1 with redirect_pc_in=0x1003 while 2 entries are buffered -> the next cycle gives valid=0 and instr_address_out=0x1000, and the first post-redirect word pops with pc_out=0x1000.
- REQ-034: fetch_pc=0xFFFFFFFC with one grant -> the entry has pc 0xFFFFFFFC and the next address is 0x0.
- REQ-035: With stats enabled, ready held at 0 for 3 requesting cycles -> stall_cycles_out=3; reset then returns it to 0.
